wb_bypass_regfile: RTL and testbench

- Parametrised register file for the pipelined core. Synchronous write-back port plus NUM_RD registered read ports.
- Built-in write-back bypass: a read issued in the same cycle as a matching write returns the new write data.
- Generalises the existing two-port combinational WB forwarding mux. Adds storage, a configurable port count and width, read-enable hold, and an optional pending-write scoreboard.
- Sits between the ID stage (reads) and the WB stage (writes).

---
 rtl/wb_bypass_regfile.sv | 145 ++++++++++++++
 tb/tb_wb_bypass_regfile.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_bypass_regfile.sv
// Register file with NUM_RD registered read ports and write-back bypass.
// Optional pending-write scoreboard is built when WB_SCOREBOARD_EN is defined.
module wb_bypass_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_fwd,
`ifdef WB_SCOREBOARD_EN
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [NUM_RD-1:0]        rd_busy,
`endif
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data
);

    localparam int   DEPTH   = 1 << ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 32'sd0);

    logic [DATA_W-1:0]        mem_r [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_data_r;
    logic [NUM_RD*DATA_W-1:0] rd_data_nxt_s;
    logic [NUM_RD-1:0]        rd_fwd_r;
    logic [NUM_RD-1:0]        rd_fwd_nxt_s;
    logic [ADDR_W-1:0]        rd_addr_s [NUM_RD];
    logic [NUM_RD-1:0]        rd_zero_s;
    logic [NUM_RD-1:0]        fwd_s;
    logic                     wr_ok_s;

    // A write to the hardwired zero register is neither stored nor bypassed.
    assign wr_ok_s = wr_en & ~(ZERO_EN & (wr_addr == {ADDR_W{1'b0}}));

    // Register storage: cleared by reset, written by the write-back port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 32'sd0; a < DEPTH; a++) begin
                mem_r[a] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    // Per-port capture value: bypassed write data, stored data, or hold.
    always_comb begin
        rd_data_nxt_s = rd_data_r;
        rd_fwd_nxt_s  = rd_fwd_r;
        for (int i = 32'sd0; i < NUM_RD; i++) begin
            rd_addr_s[i] = rd_addr[i*ADDR_W +: ADDR_W];
            rd_zero_s[i] = ZERO_EN & (rd_addr_s[i] == {ADDR_W{1'b0}});
            fwd_s[i]     = wr_ok_s & (wr_addr == rd_addr_s[i]);
            if (rd_en[i]) begin
                rd_fwd_nxt_s[i] = fwd_s[i];
                if (rd_zero_s[i]) begin
                    rd_data_nxt_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                end else if (fwd_s[i]) begin
                    rd_data_nxt_s[i*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data_nxt_s[i*DATA_W +: DATA_W] = mem_r[rd_addr_s[i]];
                end
            end else begin
                rd_fwd_nxt_s[i] = rd_fwd_r[i];
            end
        end
    end

    // Read output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {(NUM_RD*DATA_W){1'b0}};
            rd_fwd_r  <= {NUM_RD{1'b0}};
        end else begin
            rd_data_r <= rd_data_nxt_s;
            rd_fwd_r  <= rd_fwd_nxt_s;
        end
    end

    assign rd_data = rd_data_r;
    assign rd_fwd  = rd_fwd_r;

`ifdef WB_SCOREBOARD_EN
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_clr_s;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [NUM_RD-1:0] rd_busy_r;
    logic [NUM_RD-1:0] rd_busy_nxt_s;

    // Busy vector update: retire first, then a new issue overrides the retire.
    always_comb begin
        busy_clr_s = busy_r;
        if (wr_en) begin
            busy_clr_s[wr_addr] = 1'b0;
        end else begin
            busy_clr_s = busy_r;
        end
        busy_nxt_s = busy_clr_s;
        if (iss_en) begin
            busy_nxt_s[iss_addr] = 1'b1;
        end else begin
            busy_nxt_s = busy_clr_s;
        end
        if (ZERO_EN) begin
            busy_nxt_s[0] = 1'b0;
        end else begin
            busy_nxt_s[0] = busy_nxt_s[0];
        end
    end

    // Reads see the post-retire, pre-issue busy state.
    always_comb begin
        rd_busy_nxt_s = rd_busy_r;
        for (int i = 32'sd0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
                rd_busy_nxt_s[i] = busy_clr_s[rd_addr[i*ADDR_W +: ADDR_W]];
            end else begin
                rd_busy_nxt_s[i] = rd_busy_r[i];
            end
        end
    end

    // Scoreboard and busy output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r    <= {DEPTH{1'b0}};
            rd_busy_r <= {NUM_RD{1'b0}};
        end else begin
            busy_r    <= busy_nxt_s;
            rd_busy_r <= rd_busy_nxt_s;
        end
    end

    assign rd_busy = rd_busy_r;
`endif

endmodule

// File: tb/tb_wb_bypass_regfile.sv
// Self-checking bench for wb_bypass_regfile: directed table, scoreboard
// sequences (when WB_SCOREBOARD_EN is defined) and randomized model checks.
module tb_wb_bypass_regfile;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [NR-1:0] rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0] rd_fwd;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
`ifdef WB_SCOREBOARD_EN
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic [NR-1:0] rd_busy;
`endif

    wb_bypass_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_fwd(rd_fwd),
`ifdef WB_SCOREBOARD_EN
        .iss_en(iss_en), .iss_addr(iss_addr), .rd_busy(rd_busy),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // Reference model: architectural register contents and per-port outputs.
    logic [DW-1:0] m_mem [32];
    logic [DW-1:0] m_d [NR];
    logic          m_f [NR];
    logic          m_busy [32];
    logic          m_b [NR];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [1:0]    re;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [1:0]    ef;
    } vec_t;
    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_cycle();
        logic [AW-1:0] a;
        logic fwd;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r] = '0;
                m_busy[r] = 1'b0;
            end
            for (int p = 0; p < NR; p++) begin
                m_d[p] = '0;
                m_f[p] = 1'b0;
                m_b[p] = 1'b0;
            end
        end else begin
            for (int p = 0; p < NR; p++) begin
                if (rd_en[p]) begin
                    a = rd_addr[p*AW +: AW];
                    fwd = wr_en && (wr_addr == a) && (wr_addr != 0);
                    m_f[p] = fwd;
                    m_d[p] = (a == 0) ? '0 : (fwd ? wr_data : m_mem[a]);
                    m_b[p] = (wr_en && wr_addr == a) ? 1'b0 : m_busy[a];
                end
            end
            if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
            if (wr_en) m_busy[wr_addr] = 1'b0;
`ifdef WB_SCOREBOARD_EN
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
`endif
        end
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        for (int p = 0; p < NR; p++) begin
            check($sformatf("%s_data%0d", tag, p), rd_data[p*DW +: DW], m_d[p]);
            check($sformatf("%s_fwd%0d", tag, p), rd_fwd[p], m_f[p]);
`ifdef WB_SCOREBOARD_EN
            check($sformatf("%s_busy%0d", tag, p), rd_busy[p], m_b[p]);
`endif
        end
    endtask

    initial begin
        reset = 1'b1; rd_en = '0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef WB_SCOREBOARD_EN
        iss_en = 1'b0; iss_addr = '0;
`endif
        //           rst   we    wa     wd            re     ra0    ra1    e0            e1            ef
        tbl[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
        tbl[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5,  32'h0,        32'h0,        2'b00};
        tbl[2]  = '{1'b0, 1'b1, 5'd7,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
        tbl[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b01, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00};
        tbl[4]  = '{1'b0, 1'b1, 5'd4,  32'h00000044, 2'b00, 5'd0,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00};
        tbl[5]  = '{1'b0, 1'b1, 5'd3,  32'h12345678, 2'b11, 5'd3,  5'd4,  32'h12345678, 32'h00000044, 2'b01};
        tbl[6]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 2'b11, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
        tbl[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b01, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
        tbl[8]  = '{1'b0, 1'b1, 5'd9,  32'hA5A5A5A5, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
        tbl[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b11, 5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00};
        tbl[10] = '{1'b0, 1'b1, 5'd9,  32'h00000001, 2'b00, 5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00};
        tbl[11] = '{1'b1, 1'b1, 5'd9,  32'h00000002, 2'b11, 5'd9,  5'd9,  32'h0,        32'h0,        2'b00};
        tbl[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b11, 5'd9,  5'd9,  32'h0,        32'h0,        2'b00};
        tbl[13] = '{1'b0, 1'b1, 5'd12, 32'hCAFEF00D, 2'b11, 5'd12, 5'd12, 32'hCAFEF00D, 32'hCAFEF00D, 2'b11};

        for (int v = 0; v < 14; v++) begin
            reset = tbl[v].rst; wr_en = tbl[v].we; wr_addr = tbl[v].wa; wr_data = tbl[v].wd;
            rd_en = tbl[v].re; rd_addr = {tbl[v].ra1, tbl[v].ra0};
            tick();
            check($sformatf("tbl%0d_d0", v), rd_data[DW-1:0], tbl[v].e0);
            check($sformatf("tbl%0d_d1", v), rd_data[2*DW-1:DW], tbl[v].e1);
            check($sformatf("tbl%0d_fwd", v), rd_fwd, tbl[v].ef);
            check_model($sformatf("tbl%0d_model", v));
        end
        reset = 1'b0; wr_en = 1'b0; rd_en = '0;

`ifdef WB_SCOREBOARD_EN
        iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        iss_en = 1'b0; rd_en = 2'b01; rd_addr = {5'd0, 5'd6};
        tick();
        check("sb_busy_after_iss", rd_busy[0], 1'b1);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        tick();
        check("sb_busy_bypass", rd_busy[0], 1'b0);
        check("sb_fwd_bypass", rd_fwd[0], 1'b1);
        iss_en = 1'b1; iss_addr = 5'd6; rd_en = 2'b00;
        tick();
        iss_en = 1'b0; wr_en = 1'b0; rd_en = 2'b01;
        tick();
        check("sb_set_wins", rd_busy[0], 1'b1);
        check_model("sb_model");
`endif

        for (int c = 0; c < 800; c++) begin
            reset   = ($urandom_range(0, 63) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = $urandom;
            rd_en   = NR'($urandom_range(0, 3));
            rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
`ifdef WB_SCOREBOARD_EN
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = AW'($urandom_range(0, 7));
`endif
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
